i2c_cmd_sequencer: RTL and testbench



---
 rtl/i2c_cmd_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_i2c_cmd_sequencer.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_cmd_sequencer.sv
// Command FIFO and one-at-a-time issue sequencer in front of an I2C master core.
// Optional transaction watchdog enabled by defining I2C_SEQ_TIMEOUT_EN.
module i2c_cmd_sequencer #(
    parameter int unsigned DEPTH = 4
`ifdef I2C_SEQ_TIMEOUT_EN
    , parameter int unsigned TIMEOUT = 1023
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [6:0] cmd_addr,
    input  logic [7:0] cmd_data,
    input  logic       cmd_stop,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_error,
    output logic       rsp_timeout,
    output logic       m_enable,
    output logic       m_mode,
    output logic [6:0] m_slave_addr,
    output logic [7:0] m_data,
    output logic       m_stop,
    input  logic [7:0] m_recv_buf,
    input  logic       m_busy,
    input  logic       m_done,
    input  logic       m_error
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t state_q, state_d;

    logic [16:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push;
    logic          pop;
    logic [16:0]   head;

    logic       m_enable_q, m_enable_d;
    logic       m_mode_q, m_mode_d;
    logic [6:0] m_addr_q, m_addr_d;
    logic [7:0] m_data_q, m_data_d;
    logic       m_stop_q, m_stop_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [7:0] rsp_data_q, rsp_data_d;
    logic       rsp_error_q, rsp_error_d;

`ifdef I2C_SEQ_TIMEOUT_EN
    localparam int unsigned WW = $clog2(TIMEOUT + 1);
    logic [WW-1:0] wdog_q, wdog_d;
    logic          rsp_timeout_q, rsp_timeout_d;
`endif

    assign cmd_ready = (count_q != CW'(DEPTH));
    assign push      = cmd_valid & cmd_ready;
    assign head      = mem_q[rd_ptr_q];

    // Entry layout: {stop, rw, addr[6:0], data[7:0]}
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cmd_stop, cmd_rw, cmd_addr, cmd_data};
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        m_enable_d  = 1'b0;
        m_mode_d    = m_mode_q;
        m_addr_d    = m_addr_q;
        m_data_d    = m_data_q;
        m_stop_d    = m_stop_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_error_d = rsp_error_q;
`ifdef I2C_SEQ_TIMEOUT_EN
        wdog_d        = wdog_q;
        rsp_timeout_d = rsp_timeout_q;
`endif
        case (state_q)
            S_IDLE: begin
                if ((count_q != '0) && !m_busy && !rsp_valid_q) begin
                    pop        = 1'b1;
                    m_stop_d   = head[16];
                    m_mode_d   = head[15];
                    m_addr_d   = head[14:8];
                    m_data_d   = head[7:0];
                    m_enable_d = 1'b1;
                    state_d    = S_WAIT;
`ifdef I2C_SEQ_TIMEOUT_EN
                    wdog_d     = '0;
`endif
                end
            end
            S_WAIT: begin
                // m_done wins over a watchdog expiry landing in the same cycle
                if (m_done) begin
                    rsp_data_d  = m_mode_q ? m_recv_buf : 8'h00;
                    rsp_error_d = m_error;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
`ifdef I2C_SEQ_TIMEOUT_EN
                    rsp_timeout_d = 1'b0;
                end else if (wdog_q == WW'(TIMEOUT)) begin
                    rsp_data_d    = 8'h00;
                    rsp_error_d   = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_valid_d   = 1'b1;
                    state_d       = S_RESP;
                end else begin
                    wdog_d = wdog_q + 1'b1;
`endif
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            m_enable_q  <= 1'b0;
            m_mode_q    <= 1'b0;
            m_addr_q    <= '0;
            m_data_q    <= '0;
            m_stop_q    <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            m_enable_q  <= m_enable_d;
            m_mode_q    <= m_mode_d;
            m_addr_q    <= m_addr_d;
            m_data_q    <= m_data_d;
            m_stop_q    <= m_stop_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_error_q <= rsp_error_d;
        end
    end

`ifdef I2C_SEQ_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdog_q        <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            wdog_q        <= wdog_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign rsp_timeout = rsp_timeout_q;
`else
    assign rsp_timeout = 1'b0;
`endif

    assign m_enable     = m_enable_q;
    assign m_mode       = m_mode_q;
    assign m_slave_addr = m_addr_q;
    assign m_data       = m_data_q;
    assign m_stop       = m_stop_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_error    = rsp_error_q;

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Directed bench for i2c_cmd_sequencer with a behavioural I2C master/slave model.
// With I2C_SEQ_TIMEOUT_EN defined the watchdog scenario runs with TIMEOUT = 16.
module tb_i2c_cmd_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid, cmd_ready, cmd_rw, cmd_stop;
    logic [6:0] cmd_addr;
    logic [7:0] cmd_data;
    logic       rsp_valid, rsp_ready, rsp_error, rsp_timeout;
    logic [7:0] rsp_data;
    logic       m_enable, m_mode, m_stop;
    logic [6:0] m_slave_addr;
    logic [7:0] m_data, m_recv_buf;
    logic       m_busy, m_done, m_error;

    logic       busy_m, ext_busy;
    logic [6:0] nack_addr;
    logic [7:0] rd_byte;
    logic       hang;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int log_n  = 0;
    logic [6:0] log_addr [64];
    logic [7:0] log_data [64];
    logic       log_mode [64];
    logic       log_stop [64];

    assign m_busy = busy_m | ext_busy;

    always #5 clk = ~clk;

    i2c_cmd_sequencer #(
        .DEPTH(4)
`ifdef I2C_SEQ_TIMEOUT_EN
        , .TIMEOUT(16)
`endif
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_stop(cmd_stop),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
        .m_enable(m_enable), .m_mode(m_mode), .m_slave_addr(m_slave_addr),
        .m_data(m_data), .m_stop(m_stop), .m_recv_buf(m_recv_buf),
        .m_busy(m_busy), .m_done(m_done), .m_error(m_error)
    );

    // Enable-pulse counter: each high sample is one cycle of m_enable
    initial begin
        forever begin
            @(negedge clk);
            if (m_enable) pulses++;
        end
    end

    // Master + slave model: busy after sampling enable, done pulse two cycles later
    initial begin
        logic       cur_err;
        logic [7:0] cur_rd;
        busy_m = 1'b0; m_done = 1'b0; m_error = 1'b0; m_recv_buf = 8'h00;
        forever begin
            @(negedge clk);
            if (m_enable && !reset) begin
                log_addr[log_n] = m_slave_addr;
                log_data[log_n] = m_data;
                log_mode[log_n] = m_mode;
                log_stop[log_n] = m_stop;
                log_n++;
                cur_err = (m_slave_addr == nack_addr);
                cur_rd  = rd_byte;
                @(negedge clk);
                busy_m = 1'b1;
                while (hang && !reset) @(negedge clk);
                if (!reset) begin
                    repeat (2) @(negedge clk);
                    m_done = 1'b1; m_error = cur_err; m_recv_buf = cur_rd;
                    @(negedge clk);
                    m_done = 1'b0; m_error = 1'b0;
                end
                busy_m = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    task automatic push_cmd(input logic rw, input logic [6:0] a, input logic [7:0] d,
                            input logic stp);
        int t = 0;
        cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = a; cmd_data = d; cmd_stop = stp;
        while (!cmd_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL push_accept addr=%h cmd_ready=%b required 1", a, cmd_ready);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string name);
        int t = 0;
        while (!rsp_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_rsp_wait rsp_valid=%b required 1", name, rsp_valid);
        end
    endtask

    task automatic consume(input string name);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if ({rsp_valid, m_enable} !== 2'b00) begin
            errors++;
            $display("FAIL %s_handshake rsp_valid,m_enable=%b required 00", name,
                     {rsp_valid, m_enable});
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({m_enable, m_mode, m_slave_addr, m_data, m_stop} !== {1'b0, 1'b0, 7'h00, 8'h00, 1'b1}) begin
            errors++;
            $display("FAIL reset_master en=%b mode=%b addr=%h data=%h stop=%b required 0 0 00 00 1",
                     m_enable, m_mode, m_slave_addr, m_data, m_stop);
        end
        checks++;
        if ({rsp_valid, rsp_data, rsp_error, rsp_timeout, cmd_ready} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_rsp valid=%b data=%h err=%b to=%b ready=%b required 0 00 0 0 1",
                     rsp_valid, rsp_data, rsp_error, rsp_timeout, cmd_ready);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write();
        int pb = pulses;
        int lb = log_n;
        rd_byte = 8'h5A;
        push_cmd(1'b0, 7'h50, 8'hA5, 1'b1);
        checks++;
        if (m_enable !== 1'b0) begin
            errors++;
            $display("FAIL write_en_E0 m_enable=%b required 0", m_enable);
        end
        @(negedge clk);
        checks++;
        if ({m_enable, m_mode, m_slave_addr, m_data, m_stop} !== {1'b1, 1'b0, 7'h50, 8'hA5, 1'b1}) begin
            errors++;
            $display("FAIL write_issue en=%b mode=%b addr=%h data=%h stop=%b required 1 0 50 a5 1",
                     m_enable, m_mode, m_slave_addr, m_data, m_stop);
        end
        @(negedge clk);
        checks++;
        if (m_enable !== 1'b0) begin
            errors++;
            $display("FAIL write_en_E2 m_enable=%b required 0", m_enable);
        end
        wait_rsp("write");
        checks++;
        if ({rsp_data, rsp_error, rsp_timeout} !== {8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL write_rsp data=%h err=%b to=%b required 00 0 0", rsp_data, rsp_error, rsp_timeout);
        end
        checks++;
        if ((pulses - pb) != 1 || (log_n - lb) != 1) begin
            errors++;
            $display("FAIL write_pulses got=%0d/%0d required 1/1", pulses - pb, log_n - lb);
        end
        consume("write");
    endtask

    task automatic test_read();
        int lb = log_n;
        rd_byte = 8'h96;
        push_cmd(1'b1, 7'h3C, 8'h77, 1'b1);
        wait_rsp("read");
        checks++;
        if ({rsp_data, rsp_error, rsp_timeout} !== {8'h96, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL read_rsp data=%h err=%b to=%b required 96 0 0", rsp_data, rsp_error, rsp_timeout);
        end
        checks++;
        if ({log_mode[lb], log_addr[lb]} !== {1'b1, 7'h3C}) begin
            errors++;
            $display("FAIL read_issue mode=%b addr=%h required 1 3c", log_mode[lb], log_addr[lb]);
        end
        consume("read");
    endtask

    task automatic test_nack();
        int lb = log_n;
        nack_addr = 7'h11;
        rd_byte   = 8'h96;
        push_cmd(1'b0, 7'h11, 8'h22, 1'b1);
        push_cmd(1'b1, 7'h3C, 8'h00, 1'b1);
        wait_rsp("nack1");
        checks++;
        if ({rsp_data, rsp_error} !== {8'h00, 1'b1}) begin
            errors++;
            $display("FAIL nack_rsp data=%h err=%b required 00 1", rsp_data, rsp_error);
        end
        consume("nack1");
        wait_rsp("nack2");
        checks++;
        if ({rsp_data, rsp_error, log_addr[lb+1], log_mode[lb+1]} !== {8'h96, 1'b0, 7'h3C, 1'b1}) begin
            errors++;
            $display("FAIL nack_next data=%h err=%b addr=%h mode=%b required 96 0 3c 1",
                     rsp_data, rsp_error, log_addr[lb+1], log_mode[lb+1]);
        end
        consume("nack2");
        nack_addr = 7'h7F;
    endtask

    task automatic test_busy_gate();
        int pb = pulses;
        ext_busy = 1'b1;
        push_cmd(1'b0, 7'h45, 8'h01, 1'b0);
        repeat (5) @(negedge clk);
        checks++;
        if (pulses != pb) begin
            errors++;
            $display("FAIL busy_hold pulses=%0d required 0", pulses - pb);
        end
        ext_busy = 1'b0;
        @(negedge clk);
        checks++;
        if ({m_enable, m_slave_addr, m_stop} !== {1'b1, 7'h45, 1'b0}) begin
            errors++;
            $display("FAIL busy_release en=%b addr=%h stop=%b required 1 45 0", m_enable, m_slave_addr, m_stop);
        end
        wait_rsp("busy");
        consume("busy");
    endtask

    task automatic test_back_to_back();
        int pb = pulses;
        int lb = log_n;
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_cmd(1'b0, 7'h20 + 7'(i), 8'hC0 + 8'(i), 1'b1);
        end
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_ready cmd_ready=%b required 0", cmd_ready);
        end
        cmd_valid = 1'b1; cmd_addr = 7'h2F; cmd_data = 8'hEE; cmd_rw = 1'b0;
        repeat (3) @(negedge clk);
        cmd_valid = 1'b0;
        wait_rsp("full_first");
        repeat (4) @(negedge clk);
        checks++;
        if ((pulses - pb) != 1 || cmd_ready !== 1'b0 || rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL full_single_issue pulses=%0d ready=%b valid=%b required 1 0 1",
                     pulses - pb, cmd_ready, rsp_valid);
        end
        for (int i = 0; i < 5; i++) begin
            wait_rsp("drain");
            checks++;
            if ({log_addr[lb+i], log_data[lb+i], rsp_data} !== {7'h20 + 7'(i), 8'hC0 + 8'(i), 8'h00}) begin
                errors++;
                $display("FAIL drain_order idx=%0d addr=%h data=%h rsp=%h required %h %h 00", i,
                         log_addr[lb+i], log_data[lb+i], rsp_data, 7'h20 + 7'(i), 8'hC0 + 8'(i));
            end
            consume("drain");
        end
        repeat (8) @(negedge clk);
        checks++;
        if ((pulses - pb) != 5 || (log_n - lb) != 5) begin
            errors++;
            $display("FAIL drain_count pulses=%0d txns=%0d required 5 5", pulses - pb, log_n - lb);
        end
    endtask

`ifdef I2C_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        hang = 1'b1;
        push_cmd(1'b1, 7'h40, 8'h00, 1'b1);
        @(negedge clk);
        checks++;
        if (m_enable !== 1'b1) begin
            errors++;
            $display("FAIL to_issue m_enable=%b required 1", m_enable);
        end
        @(negedge clk);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 15) begin
                checks++;
                if (rsp_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL to_early rsp_valid=%b required 0", rsp_valid);
                end
            end
        end
        checks++;
        if ({rsp_valid, rsp_timeout, rsp_error, rsp_data} !== {1'b1, 1'b1, 1'b1, 8'h00}) begin
            errors++;
            $display("FAIL to_fire valid=%b to=%b err=%b data=%h required 1 1 1 00",
                     rsp_valid, rsp_timeout, rsp_error, rsp_data);
        end
        hang = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_timeout, rsp_error, rsp_data} !== {1'b1, 1'b1, 1'b1, 8'h00}) begin
            errors++;
            $display("FAIL to_stale valid=%b to=%b err=%b data=%h required 1 1 1 00",
                     rsp_valid, rsp_timeout, rsp_error, rsp_data);
        end
        consume("timeout");
    endtask
`endif

    task automatic test_reset_mid();
        int pb;
        hang = 1'b1;
        push_cmd(1'b0, 7'h30, 8'h01, 1'b1);
        push_cmd(1'b0, 7'h31, 8'h02, 1'b1);
        push_cmd(1'b0, 7'h32, 8'h03, 1'b1);
        repeat (2) @(negedge clk);
        pb = pulses;
        reset = 1'b1;
        #1;
        checks++;
        if ({m_enable, m_slave_addr, m_data, m_stop, rsp_valid, cmd_ready} !==
            {1'b0, 7'h00, 8'h00, 1'b1, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_mid en=%b addr=%h data=%h stop=%b valid=%b ready=%b required 0 00 00 1 0 1",
                     m_enable, m_slave_addr, m_data, m_stop, rsp_valid, cmd_ready);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        hang  = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (pulses != pb || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_after pulses=%0d valid=%b required 0 0", pulses - pb, rsp_valid);
        end
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = '0; cmd_data = '0;
        cmd_stop = 1'b1; rsp_ready = 1'b0; ext_busy = 1'b0; nack_addr = 7'h7F;
        rd_byte = 8'h00; hang = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_nack();
        test_busy_gate();
        test_back_to_back();
`ifdef I2C_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
